// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader and its latency counter.
package rf_dump_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Register 0 is hardwired to zero in the register file.
  localparam int REG_ZERO = 0;

  // Wide enough to hold RD_LAT-1 for RD_LAT in 1..4.
  localparam int LAT_W = 2;

endpackage

// File: rtl/rf_dump_reader_if.sv
// Read-port and dump-stream signals of the dump reader, grouped for port connection.
interface rf_dump_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  oRdEn;
  logic [ADDR_WIDTH-1:0] oRdAddr;
  logic                  iRdGnt;
  logic [DATA_WIDTH-1:0] iRdData;
  logic                  oDumpValid;
  logic [ADDR_WIDTH-1:0] oDumpAddr;
  logic [DATA_WIDTH-1:0] oDumpData;
  logic                  oDumpLast;
  logic                  iDumpReady;

  modport master (
    output oRdEn, oRdAddr,
    input  iRdGnt, iRdData,
    output oDumpValid, oDumpAddr, oDumpData, oDumpLast,
    input  iDumpReady
  );

  modport slave (
    input  oRdEn, oRdAddr,
    output iRdGnt, iRdData,
    input  oDumpValid, oDumpAddr, oDumpData, oDumpLast,
    output iDumpReady
  );

endinterface

// File: rtl/rf_dump_lat_ctr.sv
// Read-latency down-counter; strobes o_capture on the cycle the read data is valid.
module rf_dump_lat_ctr
  import rf_dump_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic i_load,
  input  logic i_run,
  input  logic i_clear,
  output logic o_capture
);

  logic [LAT_W-1:0] r_lat;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_lat <= '0;
    end else if (i_clear) begin
      r_lat <= '0;
    end else if (i_load) begin
      r_lat <= LAT_W'(RD_LAT - 1);
    end else if (i_run && (r_lat != '0)) begin
      r_lat <= r_lat - LAT_W'(1);
    end
  end

  assign o_capture = i_run && (r_lat == '0);

endmodule

// File: rtl/rf_dump_reader.sv
// Walks the register file from START_REG to the top register and streams {addr, data} beats.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int START_REG  = 1,
  parameter int RD_LAT     = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  rf_dump_reader_if.master bus,
  output logic             oBusy,
  output logic             oDone
);

  localparam logic [ADDR_WIDTH-1:0] START_CNT = ADDR_WIDTH'(START_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = '1;

  state_e                r_state;
  state_e                w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_grant;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_capture;

  assign w_grant = (r_state == ST_ISSUE)   && bus.iRdGnt;
  assign w_beat  = (r_state == ST_PRESENT) && bus.iDumpReady;
  assign w_last  = (r_cnt == LAST_REG);

  rf_dump_lat_ctr #(
    .RD_LAT (RD_LAT)
  ) u_lat_ctr (
    .iClk      (iClk),
    .iRst      (iRst),
    .i_load    (w_grant),
    .i_run     (r_state == ST_WAIT),
    .i_clear   (iAbort),
    .o_capture (w_capture)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (iAbort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (iStart)         w_next = ST_ISSUE;
        ST_ISSUE:   if (bus.iRdGnt)     w_next = ST_WAIT;
        ST_WAIT:    if (w_capture)      w_next = ST_PRESENT;
        ST_PRESENT: if (bus.iDumpReady) w_next = w_last ? ST_DONE : ST_ISSUE;
        ST_DONE:                        w_next = ST_IDLE;
        default:                        w_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: the data register is a single flop bank, not a memory, so it is reset like any other state.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cnt  <= START_CNT;
      r_data <= '0;
    end else if (!iAbort) begin
      if ((r_state == ST_IDLE) && iStart) begin
        r_cnt <= START_CNT;
      end else if (w_beat && !w_last) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end
      if (w_capture) begin
        r_data <= (r_cnt == ADDR_WIDTH'(REG_ZERO)) ? '0 : bus.iRdData;
      end
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    bus.oRdEn      = 1'b0;
    bus.oRdAddr    = '0;
    bus.oDumpValid = 1'b0;
    bus.oDumpAddr  = '0;
    bus.oDumpData  = '0;
    bus.oDumpLast  = 1'b0;
    oBusy          = 1'b0;
    oDone          = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        bus.oRdEn   = 1'b1;
        bus.oRdAddr = r_cnt;
        oBusy       = 1'b1;
      end
      ST_WAIT: begin
        oBusy = 1'b1;
      end
      ST_PRESENT: begin
        bus.oDumpValid = 1'b1;
        bus.oDumpAddr  = r_cnt;
        bus.oDumpData  = r_data;
        bus.oDumpLast  = w_last;
        oBusy          = 1'b1;
      end
      ST_DONE: begin
        oDone = 1'b1;
        oBusy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench: three dump readers with different latency/start settings against a register-file model.
`timescale 1ns/1ps
module tb_rf_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic a_start, a_abort, a_busy, a_done;
  logic b_start, b_abort, b_busy, b_done;
  logic c_start, c_abort, c_busy, c_done;

  rf_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  rf_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();
  rf_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_c ();

  rf_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_REG(1), .RD_LAT(1)) dut_a (
    .iClk(clk), .iRst(rst), .iStart(a_start), .iAbort(a_abort),
    .bus(bus_a), .oBusy(a_busy), .oDone(a_done));

  rf_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_REG(0), .RD_LAT(3)) dut_b (
    .iClk(clk), .iRst(rst), .iStart(b_start), .iAbort(b_abort),
    .bus(bus_b), .oBusy(b_busy), .oDone(b_done));

  rf_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_REG(31), .RD_LAT(2)) dut_c (
    .iClk(clk), .iRst(rst), .iStart(c_start), .iAbort(c_abort),
    .bus(bus_c), .oBusy(c_busy), .oDone(c_done));

  // Register file contents: Rn = 0x1000_0000 + n; R0 reads back junk so forcing to zero is visible.
  function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
    return (a == '0) ? 32'hDEAD_BEEF : 32'h1000_0000 + {27'd0, a};
  endfunction

  // Read-port model: data appears exactly RD_LAT cycles after an accepted request, junk otherwise.
  logic [2:0]    a_vld, b_vld, c_vld;
  logic [AW-1:0] a_pipe [3];
  logic [AW-1:0] b_pipe [3];
  logic [AW-1:0] c_pipe [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld <= '0; b_vld <= '0; c_vld <= '0;
    end else begin
      a_vld <= {a_vld[1:0], bus_a.oRdEn && bus_a.iRdGnt};
      b_vld <= {b_vld[1:0], bus_b.oRdEn && bus_b.iRdGnt};
      c_vld <= {c_vld[1:0], bus_c.oRdEn && bus_c.iRdGnt};
      a_pipe[0] <= bus_a.oRdAddr;
      b_pipe[0] <= bus_b.oRdAddr;
      c_pipe[0] <= bus_c.oRdAddr;
      for (int i = 1; i < 3; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
    end
  end

  assign bus_a.iRdData = a_vld[0] ? rf_val(a_pipe[0]) : 32'hDEAD_BEEF;
  assign bus_b.iRdData = b_vld[2] ? rf_val(b_pipe[2]) : 32'hDEAD_BEEF;
  assign bus_c.iRdData = c_vld[1] ? rf_val(c_pipe[1]) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic abort_a();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus_a.oRdEn, bus_a.oDumpValid, bus_a.oDumpLast, a_busy, a_done} !== 5'b0 ||
        bus_a.oRdAddr !== '0 || bus_a.oDumpAddr !== '0 || bus_a.oDumpData !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rden=%0b addr=%0d valid=%0b daddr=%0d data=%h last=%0b busy=%0b done=%0b, required all 0",
               bus_a.oRdEn, bus_a.oRdAddr, bus_a.oDumpValid, bus_a.oDumpAddr, bus_a.oDumpData,
               bus_a.oDumpLast, a_busy, a_done);
    end
    checks++;
    if ({b_busy, bus_b.oRdEn, c_busy, bus_c.oDumpValid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_other: b_busy=%0b b_rden=%0b c_busy=%0b c_valid=%0b, required 0",
               b_busy, bus_b.oRdEn, c_busy, bus_c.oDumpValid);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_walk();
    int exp_addr = 1;
    int busy_cyc = 0;
    bit prev_last = 1'b0;
    bit seen_done = 1'b0;
    logic [DW-1:0] exp_d;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      if (a_done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (prev_last !== 1'b1 || a_busy !== 1'b1) begin
          errors++;
          $display("FAIL full_done_timing: prev_last=%0b busy=%0b, required 1 1", prev_last, a_busy);
        end
      end else begin
        busy_cyc++;
        prev_last = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
          errors++;
          $display("FAIL full_busy: busy=%0b at cycle %0d, required 1", a_busy, cyc);
        end
        if (bus_a.oRdEn === 1'b1) begin
          checks++;
          if (bus_a.oRdAddr !== AW'(exp_addr)) begin
            errors++;
            $display("FAIL full_rdaddr: got %0d, required %0d", bus_a.oRdAddr, exp_addr);
          end
        end
        if (bus_a.oDumpValid === 1'b1) begin
          exp_d = 32'h1000_0000 + 32'(exp_addr);
          checks++;
          if (bus_a.oDumpAddr !== AW'(exp_addr) || bus_a.oDumpData !== exp_d ||
              bus_a.oDumpLast !== (exp_addr == 31)) begin
            errors++;
            $display("FAIL full_beat: addr=%0d data=%h last=%0b, required addr=%0d data=%h last=%0b",
                     bus_a.oDumpAddr, bus_a.oDumpData, bus_a.oDumpLast, exp_addr, exp_d, exp_addr == 31);
          end
          prev_last = bus_a.oDumpLast;
          exp_addr++;
        end
        tick();
      end
    end
    checks++;
    if (!seen_done || exp_addr != 32 || busy_cyc != 93) begin
      errors++;
      $display("FAIL full_summary: done_seen=%0b beats=%0d busy_cycles=%0d, required 1 31 93",
               seen_done, exp_addr - 1, busy_cyc);
    end
    tick();
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse: done=%0b busy=%0b after DONE, required 0 0", a_done, a_busy);
    end
  endtask

  task automatic test_backpressure();
    int waited = 0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (!(bus_a.oDumpValid === 1'b1 && bus_a.oDumpAddr === 5'd7) && waited < 100) begin
      tick(); waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL bp_timeout: beat for addr 7 not seen in 100 cycles, required within budget");
    end else begin
      bus_a.iDumpReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus_a.oDumpValid !== 1'b1 || bus_a.oDumpAddr !== 5'd7 ||
            bus_a.oDumpData !== 32'h1000_0007 || bus_a.oRdEn !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold[%0d]: valid=%0b addr=%0d data=%h rden=%0b, required 1 7 10000007 0",
                   i, bus_a.oDumpValid, bus_a.oDumpAddr, bus_a.oDumpData, bus_a.oRdEn);
        end
        tick();
      end
      checks++;
      if (bus_a.oDumpValid !== 1'b1 || bus_a.oDumpAddr !== 5'd7) begin
        errors++;
        $display("FAIL bp_still: valid=%0b addr=%0d after 5 stalled cycles, required 1 7",
                 bus_a.oDumpValid, bus_a.oDumpAddr);
      end
      bus_a.iDumpReady = 1'b1;
      tick();
      checks++;
      if (bus_a.oRdEn !== 1'b1 || bus_a.oRdAddr !== 5'd8 || bus_a.oDumpValid !== 1'b0) begin
        errors++;
        $display("FAIL bp_next: rden=%0b rdaddr=%0d valid=%0b, required 1 8 0",
                 bus_a.oRdEn, bus_a.oRdAddr, bus_a.oDumpValid);
      end
    end
    bus_a.iDumpReady = 1'b1;
    abort_a();
  endtask

  task automatic test_grant_stall();
    int waited = 0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (!(bus_a.oRdEn === 1'b1 && bus_a.oRdAddr === 5'd4) && waited < 100) begin
      tick(); waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL gnt_timeout: request for addr 4 not seen in 100 cycles, required within budget");
    end else begin
      bus_a.iRdGnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bus_a.oRdEn !== 1'b1 || bus_a.oRdAddr !== 5'd4) begin
          errors++;
          $display("FAIL gnt_hold[%0d]: rden=%0b rdaddr=%0d, required 1 4", i, bus_a.oRdEn, bus_a.oRdAddr);
        end
        tick();
      end
      bus_a.iRdGnt = 1'b1;
      checks++;
      if (bus_a.oRdEn !== 1'b1 || bus_a.oRdAddr !== 5'd4) begin
        errors++;
        $display("FAIL gnt_release: rden=%0b rdaddr=%0d, required 1 4", bus_a.oRdEn, bus_a.oRdAddr);
      end
      tick();
      checks++;
      if (bus_a.oRdEn !== 1'b0 || bus_a.oDumpValid !== 1'b0 || a_busy !== 1'b1) begin
        errors++;
        $display("FAIL gnt_wait: rden=%0b valid=%0b busy=%0b, required 0 0 1",
                 bus_a.oRdEn, bus_a.oDumpValid, a_busy);
      end
      tick();
      checks++;
      if (bus_a.oDumpValid !== 1'b1 || bus_a.oDumpAddr !== 5'd4 || bus_a.oDumpData !== 32'h1000_0004) begin
        errors++;
        $display("FAIL gnt_beat: valid=%0b addr=%0d data=%h, required 1 4 10000004",
                 bus_a.oDumpValid, bus_a.oDumpAddr, bus_a.oDumpData);
      end
    end
    bus_a.iRdGnt = 1'b1;
    abort_a();
  endtask

  task automatic test_abort_wait();
    int waited = 0;
    bit bad = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (!(bus_a.oRdEn === 1'b1 && bus_a.oRdAddr === 5'd10) && waited < 100) begin
      tick(); waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL abort_timeout: request for addr 10 not seen in 100 cycles, required within budget");
    end else begin
      tick();
      checks++;
      if (bus_a.oRdEn !== 1'b0 || bus_a.oDumpValid !== 1'b0 || a_busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_in_wait: rden=%0b valid=%0b busy=%0b, required 0 0 1",
                 bus_a.oRdEn, bus_a.oDumpValid, a_busy);
      end
      abort_a();
      checks++;
      if (a_busy !== 1'b0 || bus_a.oRdEn !== 1'b0 || bus_a.oDumpValid !== 1'b0 || a_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle: busy=%0b rden=%0b valid=%0b done=%0b, required 0 0 0 0",
                 a_busy, bus_a.oRdEn, bus_a.oDumpValid, a_done);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        if (bus_a.oDumpValid !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL abort_quiet: activity after abort (bad=%0b), required none", bad);
      end
    end
    a_start = 1'b1; a_abort = 1'b1; tick(); a_start = 1'b0; a_abort = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || bus_a.oRdEn !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_start: busy=%0b rden=%0b, required 0 0", a_busy, bus_a.oRdEn);
    end
    a_start = 1'b1; tick(); a_start = 1'b0;
    checks++;
    if (bus_a.oRdEn !== 1'b1 || bus_a.oRdAddr !== 5'd1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: rden=%0b rdaddr=%0d busy=%0b, required 1 1 1",
               bus_a.oRdEn, bus_a.oRdAddr, a_busy);
    end
    tick(); tick();
    checks++;
    if (bus_a.oDumpValid !== 1'b1 || bus_a.oDumpAddr !== 5'd1 || bus_a.oDumpData !== 32'h1000_0001) begin
      errors++;
      $display("FAIL abort_restart_beat: valid=%0b addr=%0d data=%h, required 1 1 10000001",
               bus_a.oDumpValid, bus_a.oDumpAddr, bus_a.oDumpData);
    end
    abort_a();
  endtask

  task automatic test_lat3_start0();
    logic [DW-1:0] exp_d;
    int exp_addr;
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      checks++;
      if (bus_b.oDumpValid !== (cyc % 5 == 0)) begin
        errors++;
        $display("FAIL lat3_valid[%0d]: valid=%0b, required %0b", cyc, bus_b.oDumpValid, cyc % 5 == 0);
      end
      if (cyc % 5 == 0) begin
        exp_addr = cyc / 5 - 1;
        exp_d = (exp_addr == 0) ? 32'h0 : 32'h1000_0000 + 32'(exp_addr);
        checks++;
        if (bus_b.oDumpAddr !== AW'(exp_addr) || bus_b.oDumpData !== exp_d) begin
          errors++;
          $display("FAIL lat3_beat[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                   cyc, bus_b.oDumpAddr, bus_b.oDumpData, exp_addr, exp_d);
        end
      end
      tick();
    end
    b_abort = 1'b1; tick(); b_abort = 1'b0;
  endtask

  task automatic test_single_last();
    c_start = 1'b1; tick(); c_start = 1'b0;
    checks++;
    if (bus_c.oRdEn !== 1'b1 || bus_c.oRdAddr !== 5'd31) begin
      errors++;
      $display("FAIL single_issue: rden=%0b rdaddr=%0d, required 1 31", bus_c.oRdEn, bus_c.oRdAddr);
    end
    tick(); tick(); tick();
    checks++;
    if (bus_c.oDumpValid !== 1'b1 || bus_c.oDumpAddr !== 5'd31 ||
        bus_c.oDumpData !== 32'h1000_001F || bus_c.oDumpLast !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: valid=%0b addr=%0d data=%h last=%0b, required 1 31 1000001f 1",
               bus_c.oDumpValid, bus_c.oDumpAddr, bus_c.oDumpData, bus_c.oDumpLast);
    end
    tick();
    checks++;
    if (c_done !== 1'b1 || bus_c.oDumpValid !== 1'b0 || c_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%0b valid=%0b busy=%0b, required 1 0 1", c_done, bus_c.oDumpValid, c_busy);
    end
    tick();
    checks++;
    if (c_done !== 1'b0 || c_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: done=%0b busy=%0b, required 0 0", c_done, c_busy);
    end
  endtask

  task automatic test_async_reset();
    int waited = 0;
    bus_a.iDumpReady = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    while (bus_a.oDumpValid !== 1'b1 && waited < 20) begin
      tick(); waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL rst_timeout: no beat within 20 cycles, required within budget");
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus_a.oDumpValid !== 1'b0 || bus_a.oRdEn !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%0b rden=%0b busy=%0b before any edge, required 0 0 0",
               bus_a.oDumpValid, bus_a.oRdEn, a_busy);
    end
    #1 rst = 1'b0;
    a_start = 1'b1;
    bus_a.iDumpReady = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || bus_a.oRdEn !== 1'b1 || bus_a.oRdAddr !== 5'd1) begin
      errors++;
      $display("FAIL rst_restart: busy=%0b rden=%0b rdaddr=%0d, required 1 1 1",
               a_busy, bus_a.oRdEn, bus_a.oRdAddr);
    end
    abort_a();
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0;
    b_start = 1'b0; b_abort = 1'b0;
    c_start = 1'b0; c_abort = 1'b0;
    bus_a.iRdGnt = 1'b1; bus_a.iDumpReady = 1'b1;
    bus_b.iRdGnt = 1'b1; bus_b.iDumpReady = 1'b1;
    bus_c.iRdGnt = 1'b1; bus_c.iDumpReady = 1'b1;

    test_reset();
    test_full_walk();
    test_backpressure();
    test_grant_stall();
    test_lat3_start0();
    test_single_last();
    test_abort_wait();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
